instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute controller for the 16-bit datapath. Drives E/FunSel of the
//  PC, IR and general register file (FunSel encoding shared with Register: 000 dec, 001 inc,
//  010 load, 011 clr, 100 clr-high/write-low, 101 write-low, 110 write-high, 111 sign-ext low).
//  Fetches the instruction as two bytes from the byte-wide memory and executes one register
//  operation per instruction.
// PARAMETERS
//  OPW   4   opcode width, IR[15:12]; fixed at 4 in this revision
//  NREG  4   general registers, one-hot enable width; fixed at 4
// PORTS
//  Clock        in   1   system clock, rising edge
//  Reset        in   1   asynchronous, active-high; forces IDLE
//  Run          in   1   start pulse, sampled only in IDLE
//  Mem_Ready    in   1   memory byte valid this cycle
//  IROut        in   16  current IR contents: [15:12] op, [11:10] reg, [7:0] imm
//  Z            in   1   ALU zero flag
//  Mem_RD       out  1   memory read strobe, address = PC
//  PC_E         out  1   PC enable
//  PC_FunSel    out  3   PC function select
//  IR_E         out  1   IR enable
//  IR_FunSel    out  3   IR function select
//  RF_RegSel    out  4   one-hot register enable, from IR[11:10] (00->0001 ... 11->1000)
//  RF_FunSel    out  3   register file function select
//  Halted       out  1   high in IDLE
//  Illegal      out  1   sticky illegal-opcode flag (trap build only, else tied 0)
//  State        out  2   00 IDLE/FETCH_L... see encoding below (debug)
// BEHAVIOUR
//  - State register only; all outputs decoded combinationally from state, IROut, Z, Mem_Ready.
//  - Reset (async): state=IDLE, Illegal=0. All E/RegSel outputs 0, FunSels 000, Mem_RD 0,
//    Halted 1. Enables fall in the same cycle Reset rises; an in-flight op is abandoned.
//  - Any FunSel drive has its E low except in the listed cycles (000 = decrement, so E must gate).
//  - States: IDLE(00 w/ Halted), FETCH_L, FETCH_H, DECODE, EXEC; State out = 0 IDLE, 1 FETCH_L,
//    2 FETCH_H, 3 DECODE/EXEC (Halted distinguishes IDLE). Use 3-bit internal encoding.
//  - IDLE: Run=1 -> FETCH_L. Run ignored in all other states.
//  - FETCH_L: Mem_RD=1. Mem_Ready=1: IR_E=1/101, PC_E=1/001, -> FETCH_H. Else hold, enables 0.
//  - FETCH_H: Mem_RD=1. Mem_Ready=1: IR_E=1/110, PC_E=1/001, -> DECODE. Else hold.
//  - DECODE: no enables, 1 cycle for IROut to settle -> EXEC.
//  - EXEC (1 cycle, -> FETCH_L unless stated):
//     0 NOP none | 1 LDI RF 100 | 2 INC RF 001 | 3 DEC RF 000 | 4 CLR RF 011 | 5 LDH RF 110
//     6 BRA PC_E=1/100 (bus = zero-extended imm) | 7 BNZ as BRA only if Z=0, else none
//     8 SEX RF 111 | F HALT none, -> IDLE | 9-E illegal (see CONFIGURATION)
//     RF ops: RF_RegSel per IR[11:10], RF_FunSel as listed.
//  - Latency: 4 cycles/instruction with Mem_Ready held high; +1 per Mem_Ready-low fetch cycle.
//  - PC wraps FFFF->0000 via Register increment; sequencer does not check.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: opcode 9-E in EXEC sets Illegal=1 (sticky until Reset), -> IDLE,
//    no enables. Undefined: 9-E execute as NOP, -> FETCH_L; Illegal tied 0.
// TESTING
//  1 Reset, Run, bytes 5A,18 (IR=185A), Ready=1 -> EXEC in cycle 4: RF_RegSel=0100, RF_FunSel=100.
//  2 Ready low 3 cycles in FETCH_L -> State held 1, PC_E=0, IR_E=0; instruction completes cycle 7.
//  3 IR=7020: Z=1 -> EXEC all enables 0; Z=0 -> PC_E=1, PC_FunSel=100.
//  4 IR=F000 -> IDLE after EXEC, Halted=1, Run restarts fetch; Run in FETCH_H has no effect.
//  5 Reset raised mid FETCH_H with Ready=1 -> IR_E, PC_E, Mem_RD drop same cycle; IDLE.
//  6 IR=A000: TRAP build -> Illegal=1, Halted=1; plain build -> NOP, next FETCH_L.

Source files
------------

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetch/decode/execute controller for the 16-bit datapath.
// It fetches each instruction as two bytes, low byte first, into IR. It then executes
// one register-file or PC operation per instruction.
// Build option: define ILLEGAL_TRAP_EN to trap opcodes 9..E. A trap sets the sticky Illegal
// flag and halts. Without it those opcodes behave as NOP and Illegal is tied low.
// FunSel codes: 000 dec, 001 inc, 010 load, 011 clr, 100 clr-high/write-low,
// 101 write-low, 110 write-high, 111 sign-ext low.
module instruction_sequencer #(
  parameter int OPW  = 4,
  parameter int NREG = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic            Mem_Ready,
  input  logic [15:0]     IROut,
  input  logic            Z,
  output logic            Mem_RD,
  output logic            PC_E,
  output logic [2:0]      PC_FunSel,
  output logic            IR_E,
  output logic [2:0]      IR_FunSel,
  output logic [NREG-1:0] RF_RegSel,
  output logic [2:0]      RF_FunSel,
  output logic            Halted,
  output logic            Illegal,
  output logic [1:0]      State
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_L = 3'd1,
    ST_FETCH_H = 3'd2,
    ST_DECODE  = 3'd3,
    ST_EXEC    = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_INC  = 4'h2;
  localparam logic [3:0] OP_DEC  = 4'h3;
  localparam logic [3:0] OP_CLR  = 4'h4;
  localparam logic [3:0] OP_LDH  = 4'h5;
  localparam logic [3:0] OP_BRA  = 4'h6;
  localparam logic [3:0] OP_BNZ  = 4'h7;
  localparam logic [3:0] OP_SEX  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_CLR   = 3'b011;
  localparam logic [2:0] FS_CHWL  = 3'b100;
  localparam logic [2:0] FS_WLOW  = 3'b101;
  localparam logic [2:0] FS_WHIGH = 3'b110;
  localparam logic [2:0] FS_SEXT  = 3'b111;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t            state_r;
  state_t            state_next_s;
  logic [OPW-1:0]    op_s;
  logic              illegal_op_s;
  logic [NREG-1:0]   onehot_s;
  logic              unused_s;

  assign op_s         = IROut[15:16-OPW];
  // Opcodes 9..E are undefined in this instruction set.
  assign illegal_op_s = (op_s >= 4'h9) && (op_s <= 4'hE);
  // IR[9:8] carries no meaning for any opcode.
  assign unused_s     = ^IROut[9:8];

  // Register-select one-hot decode from IR[11:10].
  always_comb begin
    onehot_s = {NREG{1'b0}};
    onehot_s[IROut[11:10]] = 1'b1;
  end

  // Next-state logic; Run is only looked at while idle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Run) state_next_s = ST_FETCH_L;
        else     state_next_s = ST_IDLE;
      end
      ST_FETCH_L: begin
        if (Mem_Ready) state_next_s = ST_FETCH_H;
        else           state_next_s = ST_FETCH_L;
      end
      ST_FETCH_H: begin
        if (Mem_Ready) state_next_s = ST_DECODE;
        else           state_next_s = ST_FETCH_H;
      end
      ST_DECODE: state_next_s = ST_EXEC;
      ST_EXEC: begin
        if (op_s == OP_HALT)                state_next_s = ST_IDLE;
        else if (TRAP_EN && illegal_op_s)   state_next_s = ST_IDLE;
        else                                state_next_s = ST_FETCH_L;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register; async reset abandons any in-flight instruction.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky illegal-opcode flag, cleared only by Reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                                     illegal_r <= 1'b0;
    else if ((state_r == ST_EXEC) && illegal_op_s) illegal_r <= 1'b1;
    else                                           illegal_r <= illegal_r;
  end

  assign Illegal = illegal_r;
`else
  assign Illegal = 1'b0;
`endif

  // Control decode. Every FunSel idles at 000, which is "decrement".
  // So each enable is raised only in the cycle that owns it.
  always_comb begin
    Mem_RD    = 1'b0;
    PC_E      = 1'b0;
    PC_FunSel = 3'b000;
    IR_E      = 1'b0;
    IR_FunSel = 3'b000;
    RF_RegSel = {NREG{1'b0}};
    RF_FunSel = 3'b000;
    Halted    = 1'b0;
    State     = 2'd0;
    case (state_r)
      ST_IDLE: begin
        Halted = 1'b1;
        State  = 2'd0;
      end
      ST_FETCH_L: begin
        Mem_RD = 1'b1;
        State  = 2'd1;
        if (Mem_Ready) begin
          IR_E      = 1'b1;
          IR_FunSel = FS_WLOW;
          PC_E      = 1'b1;
          PC_FunSel = FS_INC;
        end else begin
          IR_E = 1'b0;
          PC_E = 1'b0;
        end
      end
      ST_FETCH_H: begin
        Mem_RD = 1'b1;
        State  = 2'd2;
        if (Mem_Ready) begin
          IR_E      = 1'b1;
          IR_FunSel = FS_WHIGH;
          PC_E      = 1'b1;
          PC_FunSel = FS_INC;
        end else begin
          IR_E = 1'b0;
          PC_E = 1'b0;
        end
      end
      ST_DECODE: begin
        State = 2'd3;
      end
      ST_EXEC: begin
        State = 2'd3;
        case (op_s)
          OP_LDI: begin RF_RegSel = onehot_s; RF_FunSel = FS_CHWL;  end
          OP_INC: begin RF_RegSel = onehot_s; RF_FunSel = FS_INC;   end
          OP_DEC: begin RF_RegSel = onehot_s; RF_FunSel = FS_DEC;   end
          OP_CLR: begin RF_RegSel = onehot_s; RF_FunSel = FS_CLR;   end
          OP_LDH: begin RF_RegSel = onehot_s; RF_FunSel = FS_WHIGH; end
          OP_SEX: begin RF_RegSel = onehot_s; RF_FunSel = FS_SEXT;  end
          OP_BRA: begin PC_E = 1'b1; PC_FunSel = FS_CHWL; end
          OP_BNZ: begin
            if (!Z) begin
              PC_E      = 1'b1;
              PC_FunSel = FS_CHWL;
            end else begin
              PC_E      = 1'b0;
            end
          end
          OP_NOP:  PC_E = 1'b0;
          OP_HALT: PC_E = 1'b0;
          default: PC_E = 1'b0;
        endcase
      end
      default: begin
        Halted = 1'b1;
        State  = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer. IR is modelled here from the fetched bytes.
// Per-cycle expected control vectors go into a scoreboard queue and are compared at negedge.
module tb_instruction_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Run = 1'b0;
  logic        Mem_Ready = 1'b0;
  logic        Z = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic [7:0]  mem_byte = 8'h00;
  logic        Mem_RD, PC_E, IR_E, Halted, Illegal;
  logic [2:0]  PC_FunSel, IR_FunSel, RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [1:0]  State;
  logic [19:0] outv;

  typedef struct {
    logic        run;
    logic        ready;
    logic [7:0]  mb;
    logic        z;
    logic [19:0] exp;
  } step_t;

  step_t       stim[$];
  logic [19:0] sb[$];
  int          checks = 0;
  int          failures = 0;

  always #5 Clock = ~Clock;

  instruction_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Mem_Ready(Mem_Ready), .IROut(ir), .Z(Z),
    .Mem_RD(Mem_RD), .PC_E(PC_E), .PC_FunSel(PC_FunSel), .IR_E(IR_E), .IR_FunSel(IR_FunSel),
    .RF_RegSel(RF_RegSel), .RF_FunSel(RF_FunSel), .Halted(Halted), .Illegal(Illegal),
    .State(State)
  );

  assign outv = {Mem_RD, PC_E, PC_FunSel, IR_E, IR_FunSel, RF_RegSel, RF_FunSel,
                 Halted, Illegal, State};

  // Instruction register model: byte writes from memory.
  always @(posedge Clock) begin
    if (IR_E) begin
      case (IR_FunSel)
        3'b101:  ir[7:0]  <= mem_byte;
        3'b110:  ir[15:8] <= mem_byte;
        3'b100:  ir       <= {8'h00, mem_byte};
        default: ir       <= ir;
      endcase
    end
  end

  function automatic logic [19:0] ev(input logic mrd, input logic pce, input logic [2:0] pcf,
                                     input logic ire, input logic [2:0] irf,
                                     input logic [3:0] rs, input logic [2:0] rff,
                                     input logic hlt, input logic ill, input logic [1:0] st);
    return {mrd, pce, pcf, ire, irf, rs, rff, hlt, ill, st};
  endfunction

  function automatic logic [19:0] v_idle(input logic ill);
    return ev(1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b1, ill, 2'd0);
  endfunction

  function automatic logic [19:0] v_none3();
    return ev(1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b0, 1'b0, 2'd3);
  endfunction

  function automatic logic [19:0] v_rf(input logic [3:0] rs, input logic [2:0] fs);
    return ev(1'b0, 1'b0, 3'b000, 1'b0, 3'b000, rs, fs, 1'b0, 1'b0, 2'd3);
  endfunction

  function automatic logic [19:0] v_branch();
    return ev(1'b0, 1'b1, 3'b100, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b0, 1'b0, 2'd3);
  endfunction

  function automatic logic [19:0] v_fl(input logic rdy);
    if (rdy) return ev(1'b1, 1'b1, 3'b001, 1'b1, 3'b101, 4'b0000, 3'b000, 1'b0, 1'b0, 2'd1);
    else     return ev(1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b0, 1'b0, 2'd1);
  endfunction

  function automatic logic [19:0] v_fh();
    return ev(1'b1, 1'b1, 3'b001, 1'b1, 3'b110, 4'b0000, 3'b000, 1'b0, 1'b0, 2'd2);
  endfunction

  task automatic add(input logic run, input logic rdy, input logic [7:0] mb, input logic z,
                     input logic [19:0] e);
    step_t s;
    s.run = run; s.ready = rdy; s.mb = mb; s.z = z; s.exp = e;
    stim.push_back(s);
  endtask

  // Queue FETCH_L, FETCH_H and DECODE cycles for one instruction word.
  task automatic add_fetch(input logic [15:0] w, input logic run_h);
    add(1'b0, 1'b1, w[7:0], 1'b0, v_fl(1'b1));
    add(run_h, 1'b1, w[15:8], 1'b0, v_fh());
    add(1'b0, 1'b0, 8'h00, 1'b0, v_none3());
  endtask

  task automatic test_reset();
    logic [19:0] e;
    Reset = 1'b1;
    @(negedge Clock);
    sb.push_back(v_idle(1'b0));
    e = sb.pop_front(); checks++;
    if (outv !== e) begin failures++; $display("FAIL reset_hold got=%05h exp=%05h", outv, e); end
    Run = 1'b1;
    @(negedge Clock);
    sb.push_back(v_idle(1'b0));
    e = sb.pop_front(); checks++;
    if (outv !== e) begin failures++; $display("FAIL reset_run got=%05h exp=%05h", outv, e); end
    Run = 1'b0;
    Reset = 1'b0;
    @(negedge Clock);
    sb.push_back(v_idle(1'b0));
    e = sb.pop_front(); checks++;
    if (outv !== e) begin failures++; $display("FAIL reset_release got=%05h exp=%05h", outv, e); end
  endtask

  task automatic test_ldi();
    step_t s; logic [19:0] e; int n = 0;
    add(1'b1, 1'b0, 8'h00, 1'b0, v_idle(1'b0));
    add_fetch(16'h185A, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, v_rf(4'b0100, 3'b100));
    while (stim.size() != 0) begin
      s = stim.pop_front();
      @(posedge Clock); #1;
      Run = s.run; Mem_Ready = s.ready; mem_byte = s.mb; Z = s.z;
      sb.push_back(s.exp);
      @(negedge Clock);
      e = sb.pop_front(); n++; checks++;
      if (outv !== e) begin failures++; $display("FAIL ldi step=%0d got=%05h exp=%05h", n, outv, e); end
    end
  endtask

  task automatic test_ready_stall();
    step_t s; logic [19:0] e; int n = 0;
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 8'hEE, 1'b0, v_fl(1'b0));
    add_fetch(16'h2001, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, v_rf(4'b0001, 3'b001));
    while (stim.size() != 0) begin
      s = stim.pop_front();
      @(posedge Clock); #1;
      Run = s.run; Mem_Ready = s.ready; mem_byte = s.mb; Z = s.z;
      sb.push_back(s.exp);
      @(negedge Clock);
      e = sb.pop_front(); n++; checks++;
      if (outv !== e) begin failures++; $display("FAIL stall step=%0d got=%05h exp=%05h", n, outv, e); end
    end
  endtask

  task automatic test_branch();
    step_t s; logic [19:0] e; int n = 0;
    add_fetch(16'h7020, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b1, v_none3());
    add_fetch(16'h7020, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, v_branch());
    while (stim.size() != 0) begin
      s = stim.pop_front();
      @(posedge Clock); #1;
      Run = s.run; Mem_Ready = s.ready; mem_byte = s.mb; Z = s.z;
      sb.push_back(s.exp);
      @(negedge Clock);
      e = sb.pop_front(); n++; checks++;
      if (outv !== e) begin failures++; $display("FAIL bnz step=%0d got=%05h exp=%05h", n, outv, e); end
    end
  endtask

  task automatic test_opcodes();
    step_t s; logic [19:0] e; int n = 0;
    add_fetch(16'h0C00, 1'b0); add(1'b0, 1'b0, 8'h00, 1'b0, v_none3());
    add_fetch(16'h2C00, 1'b0); add(1'b0, 1'b0, 8'h00, 1'b0, v_rf(4'b1000, 3'b001));
    add_fetch(16'h3400, 1'b0); add(1'b0, 1'b0, 8'h00, 1'b0, v_rf(4'b0010, 3'b000));
    add_fetch(16'h4800, 1'b0); add(1'b0, 1'b0, 8'h00, 1'b0, v_rf(4'b0100, 3'b011));
    add_fetch(16'h5C00, 1'b0); add(1'b0, 1'b0, 8'h00, 1'b0, v_rf(4'b1000, 3'b110));
    add_fetch(16'h6055, 1'b0); add(1'b0, 1'b0, 8'h00, 1'b1, v_branch());
    add_fetch(16'h8400, 1'b0); add(1'b0, 1'b0, 8'h00, 1'b0, v_rf(4'b0010, 3'b111));
    while (stim.size() != 0) begin
      s = stim.pop_front();
      @(posedge Clock); #1;
      Run = s.run; Mem_Ready = s.ready; mem_byte = s.mb; Z = s.z;
      sb.push_back(s.exp);
      @(negedge Clock);
      e = sb.pop_front(); n++; checks++;
      if (outv !== e) begin failures++; $display("FAIL opcodes step=%0d got=%05h exp=%05h", n, outv, e); end
    end
  endtask

  task automatic test_halt_run();
    step_t s; logic [19:0] e; int n = 0;
    add_fetch(16'hF000, 1'b1);
    add(1'b0, 1'b0, 8'h00, 1'b0, v_none3());
    add(1'b0, 1'b1, 8'h00, 1'b0, v_idle(1'b0));
    add(1'b1, 1'b1, 8'h00, 1'b0, v_idle(1'b0));
    add(1'b0, 1'b1, 8'h11, 1'b0, v_fl(1'b1));
    while (stim.size() != 0) begin
      s = stim.pop_front();
      @(posedge Clock); #1;
      Run = s.run; Mem_Ready = s.ready; mem_byte = s.mb; Z = s.z;
      sb.push_back(s.exp);
      @(negedge Clock);
      e = sb.pop_front(); n++; checks++;
      if (outv !== e) begin failures++; $display("FAIL halt step=%0d got=%05h exp=%05h", n, outv, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] e;
    @(posedge Clock); #1;
    Run = 1'b0; Mem_Ready = 1'b1; mem_byte = 8'h22;
    sb.push_back(v_fh());
    @(negedge Clock);
    e = sb.pop_front(); checks++;
    if (outv !== e) begin failures++; $display("FAIL mid_fetch_h got=%05h exp=%05h", outv, e); end
    #1 Reset = 1'b1;
    sb.push_back(v_idle(1'b0));
    #1;
    e = sb.pop_front(); checks++;
    if (outv !== e) begin failures++; $display("FAIL mid_reset_drop got=%05h exp=%05h", outv, e); end
    @(negedge Clock);
    Reset = 1'b0; Mem_Ready = 1'b0;
    sb.push_back(v_idle(1'b0));
    #1;
    e = sb.pop_front(); checks++;
    if (outv !== e) begin failures++; $display("FAIL mid_reset_idle got=%05h exp=%05h", outv, e); end
  endtask

  task automatic test_illegal();
    step_t s; logic [19:0] e; int n = 0;
    add(1'b1, 1'b0, 8'h00, 1'b0, v_idle(1'b0));
    add_fetch(16'hA000, 1'b0);
    add(1'b0, 1'b0, 8'h00, 1'b0, v_none3());
`ifdef ILLEGAL_TRAP_EN
    add(1'b0, 1'b0, 8'h00, 1'b0, v_idle(1'b1));
    add(1'b0, 1'b0, 8'h00, 1'b0, v_idle(1'b1));
`else
    add(1'b0, 1'b0, 8'h00, 1'b0, v_fl(1'b0));
    add(1'b0, 1'b0, 8'h00, 1'b0, v_fl(1'b0));
`endif
    while (stim.size() != 0) begin
      s = stim.pop_front();
      @(posedge Clock); #1;
      Run = s.run; Mem_Ready = s.ready; mem_byte = s.mb; Z = s.z;
      sb.push_back(s.exp);
      @(negedge Clock);
      e = sb.pop_front(); n++; checks++;
      if (outv !== e) begin failures++; $display("FAIL illegal step=%0d got=%05h exp=%05h", n, outv, e); end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_ready_stall();
    test_branch();
    test_opcodes();
    test_halt_run();
    test_reset_mid();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
